// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the sequential pattern generator.
// LFSR tap masks are Galois right-shift polynomials for the supported widths.
package seq_pattern_gen_pkg;

  typedef enum logic [1:0] {
    INC   = 2'd0,
    DEC   = 2'd1,
    WALK1 = 2'd2,
    LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return {24'd0, LFSR_TAPS_8};
      16:      return {16'd0, LFSR_TAPS_16};
      32:      return LFSR_TAPS_32;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control and output-stream bundle of seq_pattern_gen.
// master is the generator side; slave is the requester/sink side.
interface seq_pattern_gen_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 16
);
  logic                      start;
  logic                      abort;
  logic [1:0]                mode;
  logic [WIDTH-1:0]          seed;
  logic [LEN_W-1:0]          length;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_CH*WIDTH-1:0]   out_data;
  logic                      out_last;
  logic                      busy;
  logic                      done;
  logic [LEN_W-1:0]          beat_cnt;

  modport master (
    input  start, abort, mode, seed, length, out_ready,
    output out_valid, out_data, out_last, busy, done, beat_cnt
  );

  modport slave (
    output start, abort, mode, seed, length, out_ready,
    input  out_valid, out_data, out_last, busy, done, beat_cnt
  );
endinterface

// File: rtl/seq_pattern_gen_lfsr.sv
// Combinational Galois right-shift step for the LFSR pattern mode.
// Only built with SEQ_PATTERN_GEN_LFSR_EN; WIDTH must be 8, 16 or 32.
`ifdef SEQ_PATTERN_GEN_LFSR_EN
module seq_lfsr
  import seq_pattern_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_pat,
  output logic [WIDTH-1:0] o_nxt
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  generate
    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
      $error("seq_lfsr: WIDTH must be 8, 16 or 32");
    end
  endgenerate

  assign o_nxt = (i_pat >> 1) ^ (i_pat[0] ? TAPS : '0);

endmodule
`endif

// File: rtl/seq_pattern_gen.sv
// Multi-channel pattern generator (INC/DEC/WALK1/LFSR): first beat one cycle after start, data/last held under backpressure.
// SEQ_PATTERN_GEN_LFSR_EN compiles in LFSR mode; without it mode 3 runs as INC.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 16
) (
  input logic               clk,
  input logic               rst,
  seq_pattern_gen_if.master bus
);

  generate
    if (WIDTH < 4 || WIDTH > 32 || NUM_CH < 1 || NUM_CH > WIDTH) begin : g_bad_cfg
      $error("seq_pattern_gen: WIDTH or NUM_CH out of range");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WIDTH - n));
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;

  logic             w_run;
  logic             w_xfer;
  logic             w_last;
  logic             w_start;
  logic [WIDTH-1:0] w_init;
  logic [WIDTH-1:0] w_pat_nxt;

  assign w_run   = (r_state == RUN);
  assign w_xfer  = w_run && bus.out_ready;
  assign w_last  = w_run && (r_cnt == r_len - LEN_W'(1));
  assign w_start = (r_state == IDLE) && bus.start;

`ifdef SEQ_PATTERN_GEN_LFSR_EN
  logic [WIDTH-1:0] w_lfsr_nxt;

  seq_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .i_pat (r_pat),
    .o_nxt (w_lfsr_nxt)
  );
`endif

  always_comb begin
    w_init = bus.seed;
    case (mode_e'(bus.mode))
      WALK1:   w_init = WIDTH'(1);
`ifdef SEQ_PATTERN_GEN_LFSR_EN
      LFSR:    w_init = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
`endif
      default: w_init = bus.seed;
    endcase
  end

  always_comb begin
    w_pat_nxt = r_pat + WIDTH'(1);
    case (r_mode)
      DEC:     w_pat_nxt = r_pat - WIDTH'(1);
      WALK1:   w_pat_nxt = rotl(r_pat, 1);
`ifdef SEQ_PATTERN_GEN_LFSR_EN
      LFSR:    w_pat_nxt = w_lfsr_nxt;
`endif
      default: w_pat_nxt = r_pat + WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // abort wins over a last transfer in the same cycle: back to IDLE, no done pulse
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (w_xfer && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= INC;
      r_pat  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_mode <= mode_e'(bus.mode);
      r_pat  <= w_init;
      r_len  <= bus.length;
      r_cnt  <= '0;
    end else if (w_xfer) begin
      r_pat  <= w_pat_nxt;
      r_cnt  <= r_cnt + LEN_W'(1);
    end
  end

  assign bus.out_valid = w_run;
  assign bus.out_last  = w_last;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.beat_cnt  = r_cnt;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign bus.out_data[k*WIDTH +: WIDTH] = w_run ? rotl(r_pat, k) : '0;
    end
  endgenerate

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed literal runs plus randomized traffic against a per-beat reference model.
module tb_seq_pattern_gen;

  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int LW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.WIDTH(W), .NUM_CH(NCH), .LEN_W(LW)) bus ();

  seq_pattern_gen #(.WIDTH(W), .NUM_CH(NCH), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] rx_q[$];
  logic        last_q[$];
  int          done_cnt;

  // Reference model: run phase (0 idle, 1 streaming, 2 done), beats taken, latched request
  int         m_phase, m_cnt, m_len, m_mode;
  logic [7:0] m_seed;
  bit         m_was_last;

  function automatic logic [7:0] pat_at(int md, logic [7:0] sd, int i);
    logic [7:0] p;
    case (md)
      1: return sd - 8'(i);
      2: return 8'(1) << (i % 8);
`ifdef SEQ_PATTERN_GEN_LFSR_EN
      3: begin
        p = (sd == 8'd0) ? 8'd1 : sd;
        repeat (i) p = (p >> 1) ^ (p[0] ? 8'hB8 : 8'h00);
        return p;
      end
`endif
      default: return sd + 8'(i);
    endcase
  endfunction

  function automatic logic [15:0] chans(logic [7:0] p);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k*8 +: 8] = 8'((p << k) | (p >> (8 - k)));
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_len = 0; m_mode = 0; m_seed = 8'd0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_mode  = int'(bus.mode);
          m_seed  = bus.seed;
          m_len   = int'(bus.length);
          m_cnt   = 0;
          m_phase = (m_len == 0) ? 2 : 1;
        end
        1: begin
          m_was_last = (m_cnt == m_len - 1);
          if (bus.out_ready) m_cnt++;
          if (bus.abort) m_phase = 0;
          else if (bus.out_ready && m_was_last) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    bit          prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("valid", 32'(bus.out_valid), 32'(m_phase == 1));
        check("busy", 32'(bus.busy), 32'(m_phase != 0));
        check("done", 32'(bus.done), 32'(m_phase == 2));
        check("last", 32'(bus.out_last), 32'(m_phase == 1 && m_cnt == m_len - 1));
        check("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
        if (m_phase == 1) check("data", 32'(bus.out_data), 32'(chans(pat_at(m_mode, m_seed, m_cnt))));
        if (prev_stall && bus.out_valid) begin
          check("stall_data", 32'(bus.out_data), 32'(prev_data));
          check("stall_last", 32'(bus.out_last), 32'(prev_last));
        end
        if (bus.out_valid && bus.out_ready) begin
          rx_q.push_back(bus.out_data);
          last_q.push_back(bus.out_last);
        end
        if (bus.done) done_cnt++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    last_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_run(int md, logic [7:0] sd, int len);
    bus.start  = 1'b1;
    bus.mode   = 2'(md);
    bus.seed   = sd;
    bus.length = 16'(len);
    tick();
    bus.start  = 1'b0;
    bus.mode   = 2'($urandom);
    bus.seed   = 8'($urandom);
    bus.length = 16'($urandom);
  endtask

  task automatic wait_idle(string nm, int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_ch(string nm, int ch, logic [7:0] e[$]);
    check({nm, "_count"}, 32'(rx_q.size()), 32'(e.size()));
    foreach (e[i]) if (i < rx_q.size()) check(nm, 32'(rx_q[i][ch*8 +: 8]), 32'(e[i]));
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int n;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0;
    bus.seed = 8'd0; bus.length = 16'd0; bus.out_ready = 1'b0;
    done_cnt = 0;
    fork compare_loop(); join_none
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // INC, constant ready
    clear_rx();
    bus.out_ready = 1'b1;
    start_run(0, 8'hFE, 4);
    wait_idle("t1", 50);
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01}; check_ch("t1_ch0", 0, exp_q);
    exp_q = '{8'hFD, 8'hFF, 8'h00, 8'h02}; check_ch("t1_ch1", 1, exp_q);
    foreach (last_q[i]) check("t1_last", 32'(last_q[i]), 32'(i == 3));
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_beat_cnt", 32'(bus.beat_cnt), 32'd4);

    // INC, ready toggling 1,0,0,1
    clear_rx();
    bus.out_ready = 1'b1;
    start_run(0, 8'hFE, 4);
    n = 0;
    while (bus.busy && n < 80) begin
      bus.out_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    check("t2_timeout", 32'(bus.busy), 32'd0);
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01}; check_ch("t2_ch0", 0, exp_q);
    exp_q = '{8'hFD, 8'hFF, 8'h00, 8'h02}; check_ch("t2_ch1", 1, exp_q);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // WALK1
    clear_rx();
    bus.out_ready = 1'b1;
    start_run(2, 8'h55, 10);
    wait_idle("t3", 50);
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    check_ch("t3_ch0", 0, exp_q);

    // LFSR (or INC when the feature is compiled out)
    clear_rx();
    start_run(3, 8'h00, 5);
    wait_idle("t4", 50);
`ifdef SEQ_PATTERN_GEN_LFSR_EN
    exp_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
`else
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
    check_ch("t4_ch0", 0, exp_q);

    // DEC with abort on the 2nd transfer, then a zero-length run
    clear_rx();
    start_run(1, 8'h00, 3);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) tick();
    check("t5_done_cnt", 32'(done_cnt), 32'd0);
    check("t5_beat_cnt", 32'(bus.beat_cnt), 32'd2);
    exp_q = '{8'h00, 8'hFF}; check_ch("t5_ch0", 0, exp_q);
    clear_rx();
    start_run(0, 8'h00, 0);
    check("t5_len0_done", 32'(bus.done), 32'd1);
    check("t5_len0_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("t5_len0_done_clr", 32'(bus.done), 32'd0);
    check("t5_len0_busy", 32'(bus.busy), 32'd0);
    check("t5_len0_rx", 32'(rx_q.size()), 32'd0);

    // Reset mid-run at the 3rd beat, then a clean restart
    start_run(0, 8'h33, 10);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_data", 32'(bus.out_data), 32'd0);
    check("t6_last", 32'(bus.out_last), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    clear_rx();
    start_run(0, 8'h10, 3);
    wait_idle("t6b", 50);
    exp_q = '{8'h10, 8'h11, 8'h12}; check_ch("t6b_ch0", 0, exp_q);

    // Randomized traffic: every input toggles freely, the model tracks what must happen
    for (int c = 0; c < 3000; c++) begin
      bus.start     = ($urandom % 3) == 0;
      bus.mode      = 2'($urandom);
      bus.seed      = 8'($urandom);
      bus.length    = 16'($urandom % 13);
      bus.out_ready = ($urandom % 4) != 0;
      bus.abort     = ($urandom % 12) == 0;
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("rand_end", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Parametrised multi-channel sequential pattern generator: on a start pulse it emits a programmable number of data beats on a valid/ready stream, in one of four pattern modes. Each channel carries a rotated copy of the base pattern. It supersedes the single-purpose clocked test skeletons and serves as the standard stimulus source for bench and on-chip self-test paths.

## Interface
- WIDTH, 8, pattern width per channel; legal range 4..32.
- NUM_CH, 2, number of output channels; legal range 1..WIDTH.
- LEN_W, 16, width of the beat-length and beat-count fields.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to clk.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  ends a run early; sampled only in RUN.
- mode  in  2  pattern select: 0 INC, 1 DEC, 2 WALK1, 3 LFSR; latched at start.
- seed  in  WIDTH  initial pattern; latched at start.
- length  in  LEN_W  number of beats to emit; latched at start.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_data  out  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_last  out  1  high with the final beat of a non-aborted run.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- beat_cnt  out  LEN_W  beats transferred in the current or most recent run.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - Latch mode, seed and length; clear beat_cnt.
  - If length=0, go to DONE; otherwise go to RUN.
- Initial pattern P:
  - INC/DEC: seed.
  - WALK1: 1 (seed ignored).
  - LFSR: seed, with seed=0 replaced by 1.
- RUN:
  - out_valid=1 and out_data = {rotl(P,NUM_CH-1) … rotl(P,1), P}.
  - A transfer occurs when out_valid and out_ready are both high. On a transfer, beat_cnt increments and P advances:
    - INC: P+1 mod 2^WIDTH.
    - DEC: P−1 mod 2^WIDTH.
    - WALK1: rotl(P,1).
    - LFSR: Galois right shift, P = (P>>1) ^ (P[0] ? TAPS : 0).
  - out_last=1 while beat_cnt = length−1. A transfer with out_last=1 moves to DONE.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- abort in RUN:
  - Go to IDLE next cycle, with no done pulse.
  - A transfer in the abort cycle still counts (beat_cnt increments).
  - abort takes priority over a simultaneous last transfer: next state is IDLE and done is not pulsed.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Ignored inputs:
  - start outside IDLE.
  - abort outside RUN.
  - mode, seed and length changes after start.
- beat_cnt holds its final value in IDLE until the next start.
- Reset (any time, including mid-run):
  - State IDLE; P, beat_cnt and latched fields to 0.
  - out_valid, out_last, busy and done to 0; out_data to 0.

## Timing
- start sampled at edge t: out_valid=1 from cycle t+1 with the initial pattern.
- Throughput is 1 beat/cycle while out_ready=1. A run of N beats with constant ready takes N cycles in RUN.
- done is high in the cycle after the last transfer; busy falls one cycle after that.
- length=0: done is high in cycle t+1; out_valid never asserts.
- abort at edge a: out_valid=0 and busy=0 from cycle a+1.
- No combinational path from out_ready to out_valid or out_data. out_last is registered or decoded from registers only.

## Configuration
- SEQ_PATTERN_GEN_LFSR_EN defined:
  - LFSR mode and the LFSR sub-module are compiled in.
  - WIDTH must be 8, 16 or 32; any other WIDTH is an elaboration error.
- Not defined:
  - No LFSR logic; mode 3 behaves exactly as INC.
  - WIDTH restricted only by its legal range.

## Structure
- Package seq_pattern_gen_pkg holds:
  - mode_e enum (INC, DEC, WALK1, LFSR).
  - state_e enum (IDLE, RUN, DONE).
  - LFSR tap constants: 8'hB8, 16'hB400, 32'h80200003.
  - Constant function lfsr_taps(WIDTH).
- Sub-module seq_lfsr (WIDTH-parametrised Galois step, combinational next-value) is instantiated only under SEQ_PATTERN_GEN_LFSR_EN.

## Test plan
- INC, WIDTH=8, NUM_CH=2, seed=0xFE, length=4, ready=1 → ch0 FE,FF,00,01; ch1 FD,FF,00,02; out_last on 4th beat; done the next cycle; beat_cnt=4.
- Same run with out_ready toggling 1,0,0,1… → data and out_last stable while stalled; identical beat sequence; done after the 4th transfer only.
- WALK1, length=10, seed=0x55 → ch0 01,02,04,08,10,20,40,80,01,02.
- LFSR (macro on), WIDTH=8, seed=0, length=5 → ch0 01,B8,5C,2E,17. Macro off, same stimulus → 00,01,02,03,04.
- DEC, seed=0x00, length=3, with abort asserted alongside the 2nd transfer → 00,FF seen; busy low the next cycle; done never pulses; beat_cnt=2. Then length=0 start → done one cycle later, out_valid stays 0.
- rst asserted mid-run at beat 3 → all outputs 0 immediately. After release, a start with seed=0x10 (INC) begins cleanly at 0x10.
